// File: rtl/msrv32_integer_file.sv
// ---------------------------------------------------------------------------
// msrv32_integer_file
//
// Architectural integer register file (x0..x31) of the msrv32 core. It sits
// behind the write-back mux. It provides two combinational operand read
// ports with same-cycle write-through bypass, one clocked write port, and a
// debug read port. The debug port shows committed state only.
//
// Ports
//   ms_riscv32_mp_clk_in  : core clock, rising edge active
//   ms_riscv32_mp_rst_in  : asynchronous active-low reset
//   rs_1_addr_in          : read port 1 address
//   rs_2_addr_in          : read port 2 address
//   rd_addr_in            : write address
//   wr_en_in              : write enable from write-back
//   rd_in                 : write data (write-back mux output)
//   dbg_addr_in           : debug read address
//   rs_1_out              : read data port 1 (bypassed)
//   rs_2_out              : read data port 2 (bypassed)
//   dbg_data_out          : debug read data (committed state, no bypass)
//   wr_done_out           : one-cycle pulse after each effective write
// ---------------------------------------------------------------------------
module msrv32_integer_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic [4:0]      rs_1_addr_in,
    input  logic [4:0]      rs_2_addr_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            wr_en_in,
    input  logic [XLEN-1:0] rd_in,
    input  logic [4:0]      dbg_addr_in,
    output logic [XLEN-1:0] rs_1_out,
    output logic [XLEN-1:0] rs_2_out,
    output logic [XLEN-1:0] dbg_data_out,
    output logic            wr_done_out
);

    // x0 is hardwired to zero, so storage only exists for x1..x(NREGS-1).
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic            wr_done_q;
    logic            wr_done_d;
    logic            wr_eff;

    // A write to x0 is dropped, so it counts as neither a commit nor a done.
    assign wr_eff    = wr_en_in && (rd_addr_in != 5'd0);
    assign wr_done_d = wr_eff;

    // Register storage. Reset clears every register without waiting for a
    // clock edge. Holding reset low also blocks any write on that edge.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_eff) begin
            regs_q[rd_addr_in] <= rd_in;
        end
    end

    // Write-done pulse: it reports the write committed on the previous edge.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= wr_done_d;
        end
    end

    assign wr_done_out = wr_done_q;

    // Operand read ports. Address 0 wins over bypass, so a discarded x0 write
    // can never leak onto an operand. While reset is low, every output is
    // forced to zero and bypass is off.
    always_comb begin
        rs_1_out = '0;
        rs_2_out = '0;
        if (ms_riscv32_mp_rst_in) begin
            if (rs_1_addr_in == 5'd0) begin
                rs_1_out = '0;
            end else if (wr_en_in && (rs_1_addr_in == rd_addr_in)) begin
                rs_1_out = rd_in;
            end else begin
                rs_1_out = regs_q[rs_1_addr_in];
            end

            if (rs_2_addr_in == 5'd0) begin
                rs_2_out = '0;
            end else if (wr_en_in && (rs_2_addr_in == rd_addr_in)) begin
                rs_2_out = rd_in;
            end else begin
                rs_2_out = regs_q[rs_2_addr_in];
            end
        end
    end

    // The debug port reads committed storage only and never bypasses.
    always_comb begin
        dbg_data_out = '0;
        if (ms_riscv32_mp_rst_in && (dbg_addr_in != 5'd0)) begin
            dbg_data_out = regs_q[dbg_addr_in];
        end
    end

endmodule

// File: tb/tb_msrv32_integer_file.sv
module tb_msrv32_integer_file;

    logic        clock;
    logic        rstN;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic        wrEn;
    logic [31:0] rdData;
    logic [4:0]  dbgAddr;
    logic [31:0] rs1Out;
    logic [31:0] rs2Out;
    logic [31:0] dbgOut;
    logic        wrDone;

    int total = 0;
    int bad   = 0;

    // Reference state: one word per architectural register, plus the
    // expected write-done flag.
    logic [31:0] model [0:31];
    logic        expDone;

    int runLen = 0;
    int maxRun = 0;

    msrv32_integer_file #(.XLEN(32), .NREGS(32)) dut (
        .ms_riscv32_mp_clk_in (clock),
        .ms_riscv32_mp_rst_in (rstN),
        .rs_1_addr_in         (rs1Addr),
        .rs_2_addr_in         (rs2Addr),
        .rd_addr_in           (rdAddr),
        .wr_en_in             (wrEn),
        .rd_in                (rdData),
        .dbg_addr_in          (dbgAddr),
        .rs_1_out             (rs1Out),
        .rs_2_out             (rs2Out),
        .dbg_data_out         (dbgOut),
        .wr_done_out          (wrDone)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Architectural behaviour. Reset wipes everything at once. Otherwise an
    // edge commits a write to a nonzero register and raises done for the
    // following cycle.
    always @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            expDone = 1'b0;
        end else begin
            if (wrEn && rdAddr != 5'd0) model[rdAddr] = rdData;
            expDone = wrEn && (rdAddr != 5'd0);
        end
    end

    // Expected read value: zero in reset or for x0, else the in-flight write
    // data if it targets this register, else committed state.
    function automatic logic [31:0] expRead(input logic [4:0] addr, input logic bypass);
        if (!rstN || addr == 5'd0) return 32'h0;
        if (bypass && wrEn && addr == rdAddr) return rdData;
        return model[addr];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                 input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        @(posedge clock);
        #1;
        wrEn    = we;
        rdAddr  = rd;
        rdData  = data;
        rs1Addr = a1;
        rs2Addr = a2;
        dbgAddr = ad;
    endtask

    // Cycle-by-cycle comparison against the model, sampled on the falling
    // edge, when the inputs are stable.
    always @(negedge clock) begin
        checkOutput("rs1", rs1Out, expRead(rs1Addr, 1'b1));
        checkOutput("rs2", rs2Out, expRead(rs2Addr, 1'b1));
        checkOutput("dbg", dbgOut, expRead(dbgAddr, 1'b0));
        checkOutput("wr_done", {31'h0, wrDone}, {31'h0, expDone});
    end

    // Track the longest run of consecutive write-done cycles.
    always @(negedge clock) begin
        if (wrDone) runLen = runLen + 1;
        else runLen = 0;
        if (runLen > maxRun) maxRun = runLen;
    end

    initial begin
        rstN = 1'b0;
        wrEn = 1'b0; rdAddr = 0; rdData = 0; rs1Addr = 0; rs2Addr = 0; dbgAddr = 0;
        repeat (2) @(posedge clock);
        #1 rstN = 1'b1;
        #3;
        checkOutput("reset_dbg", dbgOut, 32'h0);
        checkOutput("reset_done", {31'h0, wrDone}, 32'h0);

        // Asynchronous reset clear with no clock edge.
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
        applyStimulus(0, 0, 0, 5, 5, 5);
        #1;
        checkOutput("preload_x5", rs1Out, 32'hDEADBEEF);
        #1 rstN = 1'b0;
        #1;
        checkOutput("async_clr_rs1", rs1Out, 32'h0);
        @(posedge clock);
        #1 rstN = 1'b1;
        #1;
        checkOutput("async_clr_dbg", dbgOut, 32'h0);

        // Basic write, then read on both ports.
        applyStimulus(1, 7, 32'h12345678, 0, 0, 0);
        applyStimulus(0, 0, 0, 7, 7, 7);
        #3;
        checkOutput("basic_rs1", rs1Out, 32'h12345678);
        checkOutput("basic_rs2", rs2Out, 32'h12345678);
        checkOutput("basic_done", {31'h0, wrDone}, 32'h1);
        applyStimulus(0, 0, 0, 7, 7, 7);
        #3;
        checkOutput("basic_done_drop", {31'h0, wrDone}, 32'h0);

        // Writes to x0 are discarded.
        applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        #3;
        checkOutput("x0_same_cycle", rs1Out, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #3;
        checkOutput("x0_after", rs1Out, 32'h0);
        checkOutput("x0_done", {31'h0, wrDone}, 32'h0);
        checkOutput("x0_dbg", dbgOut, 32'h0);

        // Bypass versus committed state.
        applyStimulus(1, 3, 32'h11, 0, 0, 0);
        applyStimulus(1, 3, 32'h22, 0, 3, 3);
        #3;
        checkOutput("bypass_rs2", rs2Out, 32'h22);
        checkOutput("bypass_dbg_old", dbgOut, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 3);
        #3;
        checkOutput("bypass_dbg_new", dbgOut, 32'h22);

        // A write on an edge while reset is held is lost.
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2 rstN = 1'b0;
        applyStimulus(1, 9, 32'hA5A5A5A5, 0, 0, 9);
        applyStimulus(0, 0, 0, 9, 9, 9);
        @(posedge clock);
        #1 rstN = 1'b1;
        #3;
        checkOutput("blocked_rs1", rs1Out, 32'h0);
        checkOutput("blocked_dbg", dbgOut, 32'h0);

        // Sweep x1..x31 on back-to-back cycles.
        applyStimulus(0, 0, 0, 0, 0, 0);
        maxRun = 0;
        for (int n = 1; n < 32; n++) applyStimulus(1, n[4:0], 32'h100 * n, n[4:0], n[4:0], n[4:0]);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #3;
        checkOutput("sweep_done_run", maxRun, 32'd31);
        for (int n = 1; n < 32; n++) begin
            applyStimulus(0, 0, 0, n[4:0], n[4:0], n[4:0]);
            #3;
            checkOutput("sweep_rs1", rs1Out, 32'h100 * n);
            checkOutput("sweep_rs2", rs2Out, 32'h100 * n);
            checkOutput("sweep_dbg", dbgOut, 32'h100 * n);
        end

        // Randomized traffic with occasional mid-cycle resets. Read addresses
        // often alias the write address to exercise the bypass.
        for (int k = 0; k < 600; k++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 3) != 0), rd, $urandom,
                          ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
            if (!rstN) rstN = 1'b1;
            if ($urandom_range(0, 49) == 0) begin
                #2 rstN = 1'b0;
            end
        end
        @(posedge clock);
        #1 rstN = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
